// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types for the CC_PLL lock supervisor: state encoding, counter widths
// and the per-state output decode.
package pll_sup_pkg;

  localparam int STATE_W = 3;
  localparam int TMR_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_STDY = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_LOST       = 3'd4,
    ST_FAULT      = 3'd5
  } pll_state_e;

  typedef struct packed {
    logic pll_stdy_rst;
    logic usr_rst_n;
    logic ready;
    logic fault;
  } pll_out_t;

  // Output levels that hold for the whole time the FSM sits in a state.
  function automatic pll_out_t state_outputs(input pll_state_e st);
    pll_out_t o;
    o = '{pll_stdy_rst: 1'b1, usr_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
    case (st)
      ST_RESET_STDY: o = '{pll_stdy_rst: 1'b1, usr_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
      ST_WAIT_LOCK:  o = '{pll_stdy_rst: 1'b0, usr_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
      ST_SETTLE:     o = '{pll_stdy_rst: 1'b0, usr_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
      ST_RUN:        o = '{pll_stdy_rst: 1'b0, usr_rst_n: 1'b1, ready: 1'b1, fault: 1'b0};
      ST_LOST:       o = '{pll_stdy_rst: 1'b0, usr_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
      ST_FAULT:      o = '{pll_stdy_rst: 1'b1, usr_rst_n: 1'b0, ready: 1'b0, fault: 1'b1};
      default:       o = '{pll_stdy_rst: 1'b1, usr_rst_n: 1'b0, ready: 1'b0, fault: 1'b0};
    endcase
    return o;
  endfunction

  // Terminal value for a phase that must last n cycles (phase counter starts at 0).
  function automatic logic [TMR_W-1:0] phase_last(input int n);
    return TMR_W'(n - 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and user-side signals of the lock supervisor; master is the
// supervisor, slave is the PLL/system environment around it.
interface pll_sup_if
  import pll_sup_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic               pll_lock_i;
  logic               pll_lock_stdy_i;
  logic               retry_i;
  logic               pll_stdy_rst_o;
  logic               usr_rst_no;
  logic               ready_o;
  logic               fault_o;
  logic [STATE_W-1:0] state_o;
  logic [CNT_W-1:0]   loss_cnt_o;

  modport master (
    input  pll_lock_i, pll_lock_stdy_i, retry_i,
    output pll_stdy_rst_o, usr_rst_no, ready_o, fault_o, state_o, loss_cnt_o
  );

  modport slave (
    output pll_lock_i, pll_lock_stdy_i, retry_i,
    input  pll_stdy_rst_o, usr_rst_no, ready_o, fault_o, state_o, loss_cnt_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static asynchronous inputs, async active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability stage followed by the resolved stage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/pll_lock_supervisor.sv
// CC_PLL lock sequencer: arms the PLL, waits for lock with bounded retries,
// settles, then releases user reset. Optional loss counter: PLL_SUP_LOSS_CNT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  pll_sup_if.master bus
);

  localparam logic [TMR_W-1:0] RST_LAST    = phase_last(RST_CYCLES);
  localparam logic [TMR_W-1:0] TO_LAST     = phase_last(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] SETTLE_LAST = phase_last(SETTLE_CYCLES);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  logic [1:0]       lock_sync_s;
  logic             lock_s;
  logic             stdy_s;

  pll_state_e       state_r;
  pll_state_e       state_nxt_s;
  logic [TMR_W-1:0] phase_r;
  logic [TMR_W-1:0] phase_inc_s;
  logic [TMR_W-1:0] phase_nxt_s;
  logic [3:0]       retry_cnt_r;
  logic [3:0]       retry_inc_s;
  logic [3:0]       retry_nxt_s;
  pll_out_t         out_r;
  pll_out_t         out_nxt_s;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({bus.pll_lock_i, bus.pll_lock_stdy_i}),
    .q_o   (lock_sync_s)
  );

  assign lock_s = lock_sync_s[1];
  assign stdy_s = lock_sync_s[0];

  // One phase counter serves as arm timer, lock timeout and settle window:
  // all three restart on state entry, and it saturates instead of wrapping.
  assign phase_inc_s = (phase_r == {TMR_W{1'b1}}) ? phase_r : (phase_r + TMR_W'(1));
  assign retry_inc_s = retry_cnt_r + 4'd1;

  // Next-state, phase counter and retry bookkeeping.
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_cnt_r;
    case (state_r)
      ST_RESET_STDY: begin
        if (phase_r == RST_LAST) begin
          state_nxt_s = ST_WAIT_LOCK;
        end else begin
          state_nxt_s = ST_RESET_STDY;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt_s = ST_SETTLE;
        end else if (phase_r == TO_LAST) begin
          retry_nxt_s = retry_inc_s;
          if (retry_inc_s == RETRY_MAX) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_RESET_STDY;
          end
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      ST_SETTLE: begin
        // A dropout here only restarts the wait; it is not a lock-loss event.
        if (!(lock_s && stdy_s)) begin
          state_nxt_s = ST_WAIT_LOCK;
        end else if (phase_r == SETTLE_LAST) begin
          state_nxt_s = ST_RUN;
          retry_nxt_s = 4'd0;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (!stdy_s) begin
          state_nxt_s = ST_LOST;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOST: begin
        state_nxt_s = ST_RESET_STDY;
      end
      ST_FAULT: begin
        if (bus.retry_i) begin
          state_nxt_s = ST_RESET_STDY;
          retry_nxt_s = 4'd0;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s = ST_RESET_STDY;
        retry_nxt_s = 4'd0;
      end
    endcase

    if (state_nxt_s != state_r) begin
      phase_nxt_s = {TMR_W{1'b0}};
    end else begin
      phase_nxt_s = phase_inc_s;
    end

    out_nxt_s = state_outputs(state_nxt_s);
  end

  // State, counters and registered outputs; outputs track the state being entered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_RESET_STDY;
      phase_r     <= {TMR_W{1'b0}};
      retry_cnt_r <= 4'd0;
      out_r       <= state_outputs(ST_RESET_STDY);
    end else begin
      state_r     <= state_nxt_s;
      phase_r     <= phase_nxt_s;
      retry_cnt_r <= retry_nxt_s;
      out_r       <= out_nxt_s;
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic             loss_evt_s;
  logic [CNT_W-1:0] loss_cnt_r;

  assign loss_evt_s = (state_r == ST_RUN) && (state_nxt_s == ST_LOST);

  // Saturating count of RUN->LOST transitions, stepped on the LOST entry edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      loss_cnt_r <= {CNT_W{1'b0}};
    end else if (loss_evt_s && (loss_cnt_r != {CNT_W{1'b1}})) begin
      loss_cnt_r <= loss_cnt_r + CNT_W'(1);
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign bus.loss_cnt_o = loss_cnt_r;
`else
  assign bus.loss_cnt_o = {CNT_W{1'b0}};
`endif

  assign bus.state_o        = state_r;
  assign bus.pll_stdy_rst_o = out_r.pll_stdy_rst;
  assign bus.usr_rst_no     = out_r.usr_rst_n;
  assign bus.ready_o        = out_r.ready;
  assign bus.fault_o        = out_r.fault;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Table-driven bench for pll_lock_supervisor with a small expected-value scoreboard.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

`ifdef PLL_SUP_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  pll_sup_if #(.CNT_W(8)) bus ();

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .SETTLE_CYCLES (8),
    .MAX_RETRY     (2),
    .CNT_W         (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       prst;
    logic       urn;
    logic       rdy;
    logic       flt;
    logic [7:0] loss;
  } obs_t;

  typedef struct {
    string name;
    logic  lock;
    logic  stdy;
    logic  retry;
    int    cyc;
    obs_t  exp;
  } vec_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Output levels the specification assigns to each state.
  function automatic obs_t expect_for(logic [2:0] st, int loss);
    obs_t o;
    o.st   = st;
    o.prst = (st == 3'd0) || (st == 3'd5);
    o.urn  = (st == 3'd3);
    o.rdy  = (st == 3'd3);
    o.flt  = (st == 3'd5);
    o.loss = LOSS_EN ? 8'(loss) : 8'd0;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st   = bus.state_o;
    o.prst = bus.pll_stdy_rst_o;
    o.urn  = bus.usr_rst_no;
    o.rdy  = bus.ready_o;
    o.flt  = bus.fault_o;
    o.loss = bus.loss_cnt_o;
    return o;
  endfunction

  task automatic add(string n, logic l, logic s, logic r, int c, logic [2:0] st, int loss);
    vec_t v;
    v.name  = n;
    v.lock  = l;
    v.stdy  = s;
    v.retry = r;
    v.cyc   = c;
    v.exp   = expect_for(st, loss);
    vecs.push_back(v);
  endtask

  task automatic check(string n, obs_t exp, obs_t act);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d prst=%b urn=%b rdy=%b flt=%b loss=%0d, want st=%0d prst=%b urn=%b rdy=%b flt=%b loss=%0d",
               n, act.st, act.prst, act.urn, act.rdy, act.flt, act.loss,
               exp.st, exp.prst, exp.urn, exp.rdy, exp.flt, exp.loss);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // name, lock, stdy, retry, cycles, expected state, expected loss count
    add("rst_hold",       1'b0, 1'b0, 1'b0,  3, 3'd0, 0);
    add("rst_release",    1'b0, 1'b0, 1'b0,  1, 3'd1, 0);
    add("wait_idle",      1'b0, 1'b0, 1'b0,  5, 3'd1, 0);
    add("lock_sync",      1'b1, 1'b1, 1'b0,  2, 3'd1, 0);
    add("settle_enter",   1'b1, 1'b1, 1'b0,  1, 3'd2, 0);
    add("settle_hold",    1'b1, 1'b1, 1'b0,  7, 3'd2, 0);
    add("run_enter",      1'b1, 1'b1, 1'b0,  1, 3'd3, 0);
    add("run_lock_ign",   1'b0, 1'b1, 1'b0,  5, 3'd3, 0);
    add("loss_sync",      1'b1, 1'b0, 1'b0,  2, 3'd3, 0);
    add("lost",           1'b1, 1'b0, 1'b0,  1, 3'd4, 1);
    add("rearm",          1'b1, 1'b0, 1'b0,  1, 3'd0, 1);
    add("rearm_hold",     1'b0, 1'b0, 1'b0,  3, 3'd0, 1);
    add("rearm_end",      1'b0, 1'b0, 1'b0,  1, 3'd1, 1);
    add("wait_to1",       1'b0, 1'b0, 1'b0, 31, 3'd1, 1);
    add("timeout1",       1'b0, 1'b0, 1'b0,  1, 3'd0, 1);
    add("rearm2_hold",    1'b0, 1'b0, 1'b0,  3, 3'd0, 1);
    add("rearm2_end",     1'b0, 1'b0, 1'b0,  1, 3'd1, 1);
    add("wait_to2",       1'b0, 1'b0, 1'b0, 31, 3'd1, 1);
    add("fault",          1'b0, 1'b0, 1'b0,  1, 3'd5, 1);
    add("fault_hold",     1'b1, 1'b1, 1'b0,  5, 3'd5, 1);
    add("recover",        1'b1, 1'b1, 1'b1,  1, 3'd0, 1);
    add("rec_hold",       1'b1, 1'b1, 1'b0,  3, 3'd0, 1);
    add("rec_wait",       1'b1, 1'b1, 1'b0,  1, 3'd1, 1);
    add("rec_settle",     1'b1, 1'b1, 1'b0,  1, 3'd2, 1);
    add("rec_settle_hold",1'b1, 1'b1, 1'b0,  7, 3'd2, 1);
    add("rec_run",        1'b1, 1'b1, 1'b0,  1, 3'd3, 1);
    add("run_retry_ign",  1'b1, 1'b1, 1'b1,  1, 3'd3, 1);
    add("lost2",          1'b1, 1'b0, 1'b0,  3, 3'd4, 2);
    add("rearm3",         1'b1, 1'b1, 1'b0,  1, 3'd0, 2);
    add("rearm3_hold",    1'b1, 1'b1, 1'b0,  3, 3'd0, 2);
    add("rearm3_end",     1'b1, 1'b1, 1'b0,  1, 3'd1, 2);
    add("gl_settle",      1'b1, 1'b1, 1'b0,  1, 3'd2, 2);
    add("gl_count5",      1'b1, 1'b1, 1'b0,  5, 3'd2, 2);
    add("gl_drop",        1'b1, 1'b0, 1'b0,  1, 3'd2, 2);
    add("gl_restore",     1'b1, 1'b1, 1'b0,  1, 3'd2, 2);
    add("gl_wait",        1'b1, 1'b1, 1'b0,  1, 3'd1, 2);
    add("gl_resettle",    1'b1, 1'b1, 1'b0,  1, 3'd2, 2);
    add("gl_hold",        1'b1, 1'b1, 1'b0,  7, 3'd2, 2);
    add("gl_run",         1'b1, 1'b1, 1'b0,  1, 3'd3, 2);

    rst_n               = 1'b0;
    bus.pll_lock_i      = 1'b0;
    bus.pll_lock_stdy_i = 1'b0;
    bus.retry_i         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", expect_for(3'd0, 0), sample());

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.pll_lock_i      = vecs[i].lock;
      bus.pll_lock_stdy_i = vecs[i].stdy;
      bus.retry_i         = vecs[i].retry;
      sb.push_back(vecs[i].exp);
      repeat (vecs[i].cyc) @(posedge clk);
      #1;
      check(vecs[i].name, sb.pop_front(), sample());
    end

    // Asynchronous reset while in RUN: outputs must drop before the next edge.
    bus.retry_i = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.push_back(expect_for(3'd0, 0));
    #1;
    check("async_rst", sb.pop_front(), sample());

    // Locks already high at release: RUN 3 sync/FSM + 4 arm + 8 settle edges later, minus overlap.
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(expect_for(3'd3, 0));
    n = 0;
    while (!bus.ready_o && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n != 13) begin
      bad++;
      $display("FAIL ready_latency: got %0d cycles, want 13", n);
    end
    check("ready_after_rst", sb.pop_front(), sample());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
